// File: rtl/sha2_compress_core.sv
// sha2_compress_core: iterative SHA-256 / SHA-512 compression engine.
// Each accepted K/W beat applies UNROLL chained rounds. A short FSM
// (IDLE/RUN/FINAL/DONE) sequences the block and owns the handshakes.
// Optional feature macro: SHA2_FEEDFWD_EN -- when defined, the incoming
// chaining value is kept and added into the result during FINAL.

module sha2_round #(
    parameter int WORD_W = 32
) (
    input  logic [7:0][WORD_W-1:0] cur,   // [7]=a ... [0]=h
    input  logic [WORD_W-1:0]      k,
    input  logic [WORD_W-1:0]      w,
    output logic [7:0][WORD_W-1:0] nxt
);
    localparam int S0A = (WORD_W == 64) ? 28 : 2;
    localparam int S0B = (WORD_W == 64) ? 34 : 13;
    localparam int S0C = (WORD_W == 64) ? 39 : 22;
    localparam int S1A = (WORD_W == 64) ? 14 : 6;
    localparam int S1B = (WORD_W == 64) ? 18 : 11;
    localparam int S1C = (WORD_W == 64) ? 41 : 25;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] s0, s1, ch, maj, t1, t2;

    assign {a, b, c, d, e, f, g, h} = cur;

    // one SHA-2 round: compute T1/T2 and rotate the working words
    always_comb begin
        s0  = rotr(a, S0A) ^ rotr(a, S0B) ^ rotr(a, S0C);
        s1  = rotr(e, S1A) ^ rotr(e, S1B) ^ rotr(e, S1C);
        ch  = (e & f) ^ (~e & g);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t1  = h + s1 + ch + k + w;
        t2  = s0 + maj;
        nxt = {t1 + t2, a, b, c, d + t1, e, f, g};
    end
endmodule

module sha2_compress_core #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int UNROLL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [8*WORD_W-1:0]      h_in,
    input  logic                     kw_valid,
    output logic                     kw_ready,
    input  logic [UNROLL*WORD_W-1:0] k_in,
    input  logic [UNROLL*WORD_W-1:0] w_in,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [8*WORD_W-1:0]      h_out,
    output logic                     busy,
    output logic [6:0]               round_cnt
);
    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word
        $error("sha2_compress_core: WORD_W must be 32 or 64");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) || (ROUNDS % UNROLL) != 0 ||
        ROUNDS > 127) begin : g_bad_unroll
        $error("sha2_compress_core: UNROLL must be 1/2/4 and divide ROUNDS (<=127)");
    end

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t                              state;
    logic   [6:0]                        rcnt;
    logic   [7:0][WORD_W-1:0]            wrk;
    logic   [7:0][WORD_W-1:0]            hout_q;
    logic   [7:0][WORD_W-1:0]            fin;
    logic   [UNROLL:0][7:0][WORD_W-1:0]  chain;

    // lane 0 sees the registered state; each lane feeds the next
    assign chain[0] = wrk;
    for (genvar i = 0; i < UNROLL; i++) begin : g_lane
        sha2_round #(.WORD_W(WORD_W)) u_round (
            .cur (chain[i]),
            .k   (k_in[i*WORD_W +: WORD_W]),
            .w   (w_in[i*WORD_W +: WORD_W]),
            .nxt (chain[i+1])
        );
    end

`ifdef SHA2_FEEDFWD_EN
    logic [7:0][WORD_W-1:0] hsav;
    for (genvar j = 0; j < 8; j++) begin : g_ff
        assign fin[j] = hsav[j] + wrk[j];
    end
`else
    // chaining addition is left to the digest controller
    assign fin = wrk;
`endif

    // block sequencing, round counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rcnt   <= '0;
            wrk    <= '0;
            hout_q <= '0;
`ifdef SHA2_FEEDFWD_EN
            hsav   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    wrk   <= h_in;
`ifdef SHA2_FEEDFWD_EN
                    hsav  <= h_in;
`endif
                    rcnt  <= '0;
                    state <= RUN;
                end
                RUN: if (kw_valid) begin
                    wrk  <= chain[UNROLL];
                    rcnt <= rcnt + 7'(UNROLL);
                    if (rcnt == 7'(ROUNDS - UNROLL)) state <= FINAL;
                end
                FINAL: begin
                    hout_q <= fin;
                    state  <= DONE;
                end
                DONE: if (done_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // handshakes are pure decodes of the state register
    assign start_ready = (state == IDLE);
    assign kw_ready    = (state == RUN);
    assign done_valid  = (state == DONE);
    assign busy        = (state != IDLE);
    assign round_cnt   = rcnt;
    assign h_out       = hout_q;
endmodule
